// File: rtl/rx_adc_frontend_pkg.sv
// rtl/rx_adc_frontend_pkg.sv - shared widths, settings addresses and saturation helper for the ADC front end
package rx_adc_frontend_pkg;

    localparam int ADC_W    = 12;
    localparam int SAMPLE_W = 16;
    localparam int SET_AW   = 7;
    localparam int SET_DW   = 32;

    localparam logic [SET_AW-1:0] DCO_EN_ADDR_DEF = 7'd10;
    localparam logic [SET_AW-1:0] OFFSET_ADDR_DEF = 7'd11;

    // Clamp a 17-bit two's-complement difference into the signed 16-bit range.
    function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1])
            return v[SAMPLE_W] ? 16'h8000 : 16'h7FFF;
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/rx_adc_frontend_dcoffset.sv
// rtl/rx_adc_frontend_dcoffset.sv - offset integrator with round-toward-zero and saturating subtract
module rx_dcoffset
    import rx_adc_frontend_pkg::*;
#(
    parameter logic [SET_AW-1:0] OFFSET_ADDR = OFFSET_ADDR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dco_en,
    input  logic                serial_strobe,
    input  logic [SET_AW-1:0]   serial_addr,
    input  logic [15:0]         offset_data,
    input  logic [ADC_W-1:0]    adc_r,
    output logic [SAMPLE_W-1:0] adc_corr
);

    logic [31:0]         integ;
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] scaled;
    logic [SAMPLE_W:0]   diff;
    logic [SAMPLE_W-1:0] d;
    logic                rnd;

    assign x      = {adc_r[ADC_W-1], adc_r, 3'b000};
    // Negative integrator with a nonzero fraction rounds up, so the offset truncates toward zero.
    assign rnd    = integ[31] & (|integ[15:0]);
    assign scaled = integ[31:16] + {15'd0, rnd};
    assign diff   = {x[SAMPLE_W-1], x} - {scaled[SAMPLE_W-1], scaled};
    assign d      = sat16(diff);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            integ    <= '0;
            adc_corr <= '0;
        end else begin
            adc_corr <= d;
            if (serial_strobe && serial_addr == OFFSET_ADDR)
                integ <= {offset_data, 16'h0000};
            else if (dco_en)
                integ <= integ + {{16{d[SAMPLE_W-1]}}, d};
        end
    end

endmodule

// File: rtl/rx_adc_frontend_rssi.sv
// rtl/rx_adc_frontend_rssi.sv - leaky level and overrange accumulators with a 1024-cycle time constant
module rssi
    import rx_adc_frontend_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [ADC_W-1:0] adc_r,
    output logic [31:0]      rssi
);

    logic [25:0]      lvl_int;
    logic [25:0]      ov_int;
    logic [ADC_W-1:0] abs_val;
    logic             over;

    assign abs_val = adc_r[ADC_W-1] ? ~adc_r : adc_r;
    assign over    = (adc_r == 12'h7FF) | (adc_r == 12'h800);

    // Each accumulator settles at input*1024, so the top 16 bits track the input without wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lvl_int <= '0;
            ov_int  <= '0;
        end else if (!enable) begin
            lvl_int <= '0;
            ov_int  <= '0;
        end else begin
            lvl_int <= lvl_int + {14'd0, abs_val} - {10'd0, lvl_int[25:10]};
            ov_int  <= ov_int + (over ? 26'd65535 : 26'd0) - {10'd0, ov_int[25:10]};
        end
    end

    assign rssi = {ov_int[25:10], lvl_int[25:10]};

endmodule

// File: rtl/setting_reg.sv
// rtl/setting_reg.sv - settings-bus register loaded on a strobe to its address
module setting_reg #(
    parameter int            AW   = 7,
    parameter int            DW   = 32,
    parameter logic [AW-1:0] ADDR = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          strobe,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] value
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            value <= '0;
        else if (strobe && addr == ADDR)
            value <= data;
    end

endmodule

// File: rtl/rx_adc_frontend.sv
// rtl/rx_adc_frontend.sv - ADC input register, DC-offset removal and RSSI/overrange measurement
module rx_adc_frontend
    import rx_adc_frontend_pkg::*;
#(
    parameter logic [SET_AW-1:0] DCO_EN_ADDR = DCO_EN_ADDR_DEF,
    parameter int                DCO_EN_BIT  = 0,
    parameter logic [SET_AW-1:0] OFFSET_ADDR = OFFSET_ADDR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [SET_AW-1:0]   serial_addr,
    input  logic [SET_DW-1:0]   serial_data,
    input  logic                serial_strobe,
    input  logic [ADC_W-1:0]    adc_in,
    output logic [SAMPLE_W-1:0] adc_corr,
    output logic [31:0]         rssi
);

    logic [ADC_W-1:0]  adc_r;
    logic [SET_DW-1:0] dco_reg;
    logic              dco_en;
    logic              unused_dco;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            adc_r <= '0;
        else
            adc_r <= adc_in;
    end

    setting_reg #(.AW(SET_AW), .DW(SET_DW), .ADDR(DCO_EN_ADDR)) u_dco_reg (
        .clock  (clock),
        .reset  (reset),
        .strobe (serial_strobe),
        .addr   (serial_addr),
        .data   (serial_data),
        .value  (dco_reg)
    );

    assign dco_en     = dco_reg[DCO_EN_BIT];
    assign unused_dco = ^{dco_reg, serial_data[SET_DW-1:16]};

    rx_dcoffset #(.OFFSET_ADDR(OFFSET_ADDR)) u_dcoffset (
        .clock         (clock),
        .reset         (reset),
        .dco_en        (dco_en),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .offset_data   (serial_data[15:0]),
        .adc_r         (adc_r),
        .adc_corr      (adc_corr)
    );

    rssi u_rssi (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .adc_r  (adc_r),
        .rssi   (rssi)
    );

endmodule

// File: tb/tb_rx_adc_frontend.sv
// tb/tb_rx_adc_frontend.sv - directed self-checking bench for rx_adc_frontend
module tb_rx_adc_frontend;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic [11:0] adc_in;
    logic [15:0] adc_corr;
    logic [31:0] rssi;

    int checks = 0;
    int errors = 0;
    int integ_m;
    int d_m;

    rx_adc_frontend dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .adc_in        (adc_in),
        .adc_corr      (adc_corr),
        .rssi          (rssi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] dat);
        serial_addr   = a;
        serial_data   = dat;
        serial_strobe = 1'b1;
        tick();
        serial_strobe = 1'b0;
        serial_addr   = 7'd0;
        serial_data   = 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference DC loop: correction for input x with integrator value i.
    function automatic int model_d(input int i, input int x);
        int s;
        int r;
        s = i >>> 16;
        if (i < 0 && (i & 32'h0000FFFF) != 0) s = s + 1;
        r = x - s;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    initial begin
        reset         = 1'b0;
        enable        = 1'b1;
        serial_addr   = 7'd0;
        serial_data   = 32'd0;
        serial_strobe = 1'b0;
        adc_in        = 12'h5A5;

        ticks(3);
        chk("reset_corr", {16'd0, adc_corr}, 32'd0);
        chk("reset_rssi", rssi, 32'd0);

        adc_in = 12'h000;
        reset  = 1'b1;
        ticks(3);
        chk("post_reset_corr", {16'd0, adc_corr}, 32'd0);
        chk("post_reset_rssi", rssi, 32'd0);

        // Static offset, loop off: x=128, offset=256.
        adc_in = 12'h010;
        wr(7'd11, 32'h0000_0100);
        tick();
        chk("static_offset", {16'd0, adc_corr}, 32'h0000_FF80);
        ticks(5);
        chk("static_hold", {16'd0, adc_corr}, 32'h0000_FF80);

        // x=16376 minus offset -32768 saturates positive.
        adc_in = 12'h7FF;
        wr(7'd11, 32'h0000_8000);
        tick();
        chk("sat_pos", {16'd0, adc_corr}, 32'h0000_7FFF);
        tick();
        chk("sat_hold", {16'd0, adc_corr}, 32'h0000_7FFF);

        // Offset load during active accumulation must win; next step exercises rounding toward zero.
        wr(7'd10, 32'd1);
        ticks(3);
        wr(7'd11, 32'h0000_FF00);
        tick();
        chk("prio_load", {16'd0, adc_corr}, 32'h0000_40F8);
        tick();
        chk("round_zero", {16'd0, adc_corr}, 32'h0000_40F7);

        wr(7'd10, 32'd0);
        adc_in = 12'h100;
        wr(7'd11, 32'h0000_0000);
        tick();
        chk("loop_open", {16'd0, adc_corr}, 32'h0000_0800);

        // Closed loop tracked cycle by cycle against the reference.
        wr(7'd10, 32'd1);
        integ_m = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            d_m = model_d(integ_m, 2048);
            chk("loop_step", {16'd0, adc_corr}, {16'd0, d_m[15:0]});
            integ_m = integ_m + d_m;
        end
        chk("loop_no_overshoot", {31'd0, adc_corr[15]}, 32'd0);

        // The disabling write edge still accumulates once; afterwards the integrator freezes.
        wr(7'd10, 32'd0);
        d_m = model_d(integ_m, 2048);
        chk("freeze_edge", {16'd0, adc_corr}, {16'd0, d_m[15:0]});
        integ_m = integ_m + d_m;
        d_m = model_d(integ_m, 2048);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("freeze_hold", {16'd0, adc_corr}, {16'd0, d_m[15:0]});
        end

        wr(7'd12, 32'hFFFF_FFFF);
        tick();
        chk("iso_offset", {16'd0, adc_corr}, {16'd0, d_m[15:0]});
        ticks(4);
        chk("iso_dco_en", {16'd0, adc_corr}, {16'd0, d_m[15:0]});

        // RSSI: enable drop clears, then first-step values and convergence.
        enable = 1'b0;
        tick();
        chk("rssi_en_clear", rssi, 32'd0);
        adc_in = 12'h7FF;
        ticks(2);
        chk("rssi_held_zero", rssi, 32'd0);
        enable = 1'b1;
        tick();
        chk("rssi_step1", rssi, {16'd63, 16'd1});
        tick();
        chk("rssi_step2", rssi, {16'd127, 16'd3});
        ticks(20000);
        chk("rssi_pos_level", {31'd0, (rssi[15:0] >= 16'd2046 && rssi[15:0] <= 16'd2048)}, 32'd1);
        chk("rssi_pos_over", {31'd0, (rssi[31:16] >= 16'd65534)}, 32'd1);

        adc_in = 12'h800;
        ticks(20000);
        chk("rssi_neg_level", {31'd0, (rssi[15:0] >= 16'd2046 && rssi[15:0] <= 16'd2048)}, 32'd1);
        chk("rssi_neg_over", {31'd0, (rssi[31:16] >= 16'd65534)}, 32'd1);

        adc_in = 12'h000;
        ticks(2000);
        chk("rssi_decay_level", {31'd0, (rssi[15:0] >= 16'd250 && rssi[15:0] <= 16'd300)}, 32'd1);
        chk("rssi_decay_over", {31'd0, (rssi[31:16] >= 16'd8500 && rssi[31:16] <= 16'd9400)}, 32'd1);

        enable = 1'b0;
        tick();
        chk("rssi_final_clear", rssi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_adc_frontend.md
# rx_adc_frontend

Single-channel receive ADC front end for the radar/SDR receive path, sitting between the ADC input pins and the DDC input mux. It registers one 12-bit ADC stream and removes DC offset with a serially programmable, optionally closed-loop integrator, producing a 16-bit corrected sample. It also measures signal level (RSSI) and ADC overrange rate for AGC. Control uses the shared serial settings bus.

## Interface
- `DCO_EN_ADDR`, default 10: settings-bus address of the 32-bit DC-offset-enable register.
- `DCO_EN_BIT`, default 0: bit of that register that enables closed-loop DC correction.
- `OFFSET_ADDR`, default 11: settings-bus address that loads the offset integrator.
- `clock`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state.
- `enable`, in, 1: RSSI enable; when low, both RSSI accumulators are held at 0.
- `serial_addr`, in, 7: settings-bus address.
- `serial_data`, in, 32: settings-bus data.
- `serial_strobe`, in, 1: one-cycle write strobe.
- `adc_in`, in, 12: two's-complement ADC sample.
- `adc_corr`, out, 16: registered, DC-corrected sample.
- `rssi`, out, 32: `{over_count[15:0], level[15:0]}`.

## Operation
- Input stage: `adc_r <= adc_in` every cycle.
- Settings register:
  - On `serial_strobe && serial_addr==DCO_EN_ADDR`, `dco_reg <= serial_data`.
  - Otherwise `dco_reg` holds.
  - `dco_en = dco_reg[DCO_EN_BIT]`.
- DC offset:
  - Datapath:
    - `x = {adc_r[11], adc_r, 3'b000}`, a signed 16-bit value.
    - `integ` is a 32-bit signed register.
    - `scaled = integ[31:16] + (integ[31] & |integ[15:0])`, i.e. round toward zero.
    - `d = x - scaled`, computed at 17 bits and saturated to the signed 16-bit range [-32768, 32767].
    - `adc_corr <= d`.
  - Integrator update priority:
    - On `serial_strobe && serial_addr==OFFSET_ADDR`, `integ <= {serial_data[15:0], 16'h0}`. A settings write wins over accumulation in the same cycle.
    - Else if `dco_en`, `integ <= integ + sext32(d)`.
    - Else `integ` holds.
- RSSI level:
  - `abs = adc_r[11] ? ~adc_r : adc_r`. This is a one's-complement magnitude, 12 bits unsigned.
  - `lvl_int` is 26 bits; `lvl_int <= lvl_int + abs - lvl_int[25:10]`.
  - `level = lvl_int[25:10]`.
- Overrange:
  - `over = (adc_r==12'h7FF) | (adc_r==12'h800)`.
  - `ov_int` is 26 bits; `ov_int <= ov_int + (over ? 65535 : 0) - ov_int[25:10]`.
  - `over_count = ov_int[25:10]`.
- When `enable==0`, `lvl_int` and `ov_int` are loaded with 0 synchronously, overriding accumulation.
- Boundaries:
  - Steady-state `lvl_int` never exceeds `2047*1024`.
  - Steady-state `ov_int` never exceeds `0x3FFFC00`.
  - Neither accumulator wraps.
  - Writes to any other address leave all state unchanged.

## Timing
- Reset asserted: `adc_r`, `dco_reg`, `integ`, `adc_corr`, `lvl_int` and `ov_int` are all 0, asynchronously. Therefore `adc_corr=0` and `rssi=0`.
- `adc_in` to `adc_corr`: 2 cycles (input register, then output register).
- Offset write:
  - `integ` changes on the edge that samples the strobe.
  - `adc_corr` reflects the new offset 1 cycle later.
- DC loop:
  - Loop gain is 2^-16 per cycle, a time constant of about 65536 cycles.
  - `dco_en` takes effect the cycle after the write.
- RSSI: `adc_in` to `rssi` update is 2 cycles. Filter time constant is 1024 cycles.
- `enable` falling: `rssi` reads 0 one cycle later.

## Structure
- Shared package holds:
  - the settings-bus address constants (`DCO_EN_ADDR`, `OFFSET_ADDR` defaults);
  - the widths (ADC 12, sample 16, settings address 7, settings data 32).
- Sub-modules:
  - `setting_reg`: parameterized address, 32-bit output, reset 0. Reusable across the codebase.
  - `rx_dcoffset`: integrator, rounding and saturation.
  - `rssi`: both leaky accumulators.
- The top level instantiates these three modules and the input register.

## Test plan
- Reset: hold `reset=0`, drive `adc_in=12'h5A5` and `enable=1`. Require `adc_corr=0` and `rssi=0`. Release reset with `adc_in=0`; outputs stay 0.
- Static offset: DC loop disabled. Write `OFFSET_ADDR` with `0x0100` and drive `adc_in=12'h010`. Require `adc_corr=16'hFF80` (-128) after settling, and constant thereafter.
- Closed loop:
  - Write `DCO_EN_ADDR` with `1`. Drive `adc_in=12'h100` (x=`0x0800`).
  - Require `|adc_corr|<=8` after 2^20 cycles, with no overshoot past 0.
  - Clear enable; `integ` freezes and `adc_corr` stays constant.
- Saturation and priority:
  - Write offset `0x8000` and drive `adc_in=12'h7FF`. Require `adc_corr=16'h7FFF`.
  - With the loop enabled, assert a strobe to `OFFSET_ADDR` in the same cycle. The loaded value wins.
- RSSI:
  - `enable=1`, `adc_in=12'h7FF` for 20000 cycles. Require `rssi[15:0]` and `rssi[31:16]` within 1 of 2047 and 65535 respectively.
  - Same check for `12'h800`.
  - Then `adc_in=12'h000`: both fields decay toward 0.
- Enable and address isolation:
  - Drop `enable`. Require `rssi=0` one cycle later.
  - Strobe a non-matching address with `0xFFFFFFFF`. Require no change to `dco_en` or to the offset.
